// File: rtl/frame_req_gen.sv
`default_nettype none
// ============================================================================
//  Module      : frame_req_gen
//  Description : Per-input-port frame front end. Parses a one-byte header,
//                buffers up to 16 payload bytes, requests the destination
//                output arbiter, and streams the payload once granted.
//  Revision    : 1.0  initial release
// ============================================================================
module frame_req_gen #(
  parameter int         PORT_ID    = 0,
  parameter logic [3:0] GRANT_BASE = 4'b0100,
  parameter logic [3:0] NON_GRANT  = 4'b0000
) (
  input  logic       glb_clk,
  input  logic       glb_areset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] grant_code_0,
  input  logic [3:0] grant_code_1,
  input  logic [3:0] grant_code_2,
  input  logic [3:0] grant_code_3,
  output logic [3:0] fifo_sel_bits,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  output logic       busy
);

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_LOAD = 3'd1;
  localparam logic [2:0] c_ST_REQ  = 3'd2;
  localparam logic [2:0] c_ST_SEND = 3'd3;
  localparam logic [2:0] c_ST_GAP  = 3'd4;

  localparam logic [3:0] c_MY_GRANT = GRANT_BASE + 4'(PORT_ID);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [1:0] r_dest;
  logic [3:0] r_lenm1;
  logic [3:0] r_wptr;
  logic [3:0] r_rptr;
  logic       r_gap_cnt;
  logic       r_run;       // holds in_ready low until the first edge after reset
  logic [3:0] r_fifo_sel;
  logic [7:0] r_buf [16];

  logic       w_xfer;
  logic [3:0] w_grant_sel;
  logic       w_match;
  logic       w_last_load;
  logic       w_last_send;

  assign w_xfer      = in_valid & in_ready;
  assign w_last_load = (r_wptr == r_lenm1);
  assign w_last_send = (r_rptr == r_lenm1);

  // Only the arbiter of the latched destination can grant this frame
  always_comb begin
    w_grant_sel = grant_code_0;
    case (r_dest)
      2'd0:    w_grant_sel = grant_code_0;
      2'd1:    w_grant_sel = grant_code_1;
      2'd2:    w_grant_sel = grant_code_2;
      default: w_grant_sel = grant_code_3;
    endcase
  end

  assign w_match = (w_grant_sel == c_MY_GRANT) && (w_grant_sel != NON_GRANT);

  // State register
  always_ff @(posedge glb_clk or negedge glb_areset_n) begin
    if (!glb_areset_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE: if (w_xfer)                w_next = c_ST_LOAD;
      c_ST_LOAD: if (w_xfer && w_last_load) w_next = c_ST_REQ;
      c_ST_REQ:  if (w_match)               w_next = c_ST_SEND;
      c_ST_SEND: if (w_last_send)           w_next = c_ST_GAP;
      c_ST_GAP:  if (r_gap_cnt)             w_next = c_ST_IDLE;
      default:                              w_next = c_ST_IDLE;
    endcase
  end

  // Header fields, pointers, gap counter and the registered request
  always_ff @(posedge glb_clk or negedge glb_areset_n) begin
    if (!glb_areset_n) begin
      r_run      <= 1'b0;
      r_dest     <= 2'd0;
      r_lenm1    <= 4'd0;
      r_wptr     <= 4'd0;
      r_rptr     <= 4'd0;
      r_gap_cnt  <= 1'b0;
      r_fifo_sel <= 4'd0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        c_ST_IDLE: begin
          if (w_xfer) begin
            r_dest  <= in_data[1:0];
            r_lenm1 <= in_data[5:2];
            r_wptr  <= 4'd0;
          end
        end
        c_ST_LOAD: if (w_xfer) r_wptr <= r_wptr + 4'd1;
        c_ST_REQ:  if (w_match) r_rptr <= 4'd0;
        c_ST_SEND: if (!w_last_send) r_rptr <= r_rptr + 4'd1;
        // Enters at 0, so toggling gives exactly two GAP cycles
        c_ST_GAP:  r_gap_cnt <= ~r_gap_cnt;
        default:   r_gap_cnt <= 1'b0;
      endcase
      // Request is held from REQ through the last SEND byte
      if ((w_next == c_ST_REQ) || (w_next == c_ST_SEND)) begin
        r_fifo_sel <= 4'b0001 << r_dest;
      end else begin
        r_fifo_sel <= 4'd0;
      end
    end
  end

  // Payload store; contents are meaningless outside a frame, so no reset
  always_ff @(posedge glb_clk) begin
    if ((r_state == c_ST_LOAD) && w_xfer) begin
      r_buf[r_wptr] <= in_data;
    end
  end

  // Output decode
  always_comb begin
    in_ready      = r_run && ((r_state == c_ST_IDLE) || (r_state == c_ST_LOAD));
    out_valid     = (r_state == c_ST_SEND);
    out_data      = out_valid ? r_buf[r_rptr] : 8'd0;
    out_last      = out_valid && w_last_send;
    busy          = (r_state != c_ST_IDLE);
    fifo_sel_bits = r_fifo_sel;
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_req_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_req_gen
//  Description : Self-checking bench for frame_req_gen (PORT_ID = 2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_req_gen;

  localparam logic [3:0] c_MATCH = 4'b0110;  // GRANT_BASE + PORT_ID(2)

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] gc [4];
  logic [3:0] fifo_sel_bits;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       busy;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  frame_req_gen #(
    .PORT_ID   (2),
    .GRANT_BASE(4'b0100),
    .NON_GRANT (4'b0000)
  ) u_dut (
    .glb_clk      (clk),
    .glb_areset_n (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .grant_code_0 (gc[0]),
    .grant_code_1 (gc[1]),
    .grant_code_2 (gc[2]),
    .grant_code_3 (gc[3]),
    .fifo_sel_bits(fifo_sel_bits),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .busy         (busy)
  );

  typedef struct {
    logic [7:0] hdr;
    bit         gapped;
    int         gwait;
    bit         hold;
    logic [7:0] nxt;
    logic [3:0] exp_sel;
    int         exp_len;
  } vec_t;

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_grants(input int d, input logic [3:0] own, input logic [3:0] others);
    for (int i = 0; i < 4; i++) gc[i] = (i == d) ? own : others;
  endtask

  // Reference behaviour: header byte, L payload bytes, request 1<<d,
  // L consecutive output bytes in order, two idle-request cycles, then IDLE.
  task automatic frame(input logic [7:0] hdr, input logic [3:0] exp_sel, input int exp_len,
                       input bit gapped, input int gwait, input bit hold, input logic [7:0] nxt);
    logic [7:0] pl [16];
    int         got [20];
    int         d;
    int         i;
    int         to;
    int         n;
    int         lastpos;
    bit         v;
    bit         took;
    logic [3:0] w;
    d = int'(hdr[1:0]);
    for (int k = 0; k < 16; k++) pl[k] = 8'($urandom);
    for (int k = 0; k < 20; k++) got[k] = -1;
    set_grants(0, 4'd0, 4'd0);
    // header
    in_valid = 1'b1;
    in_data  = hdr;
    to = 0;
    while (!in_ready && to < 50) begin
      tick();
      to++;
    end
    chk("hdr_ready_timeout", int'(to < 50), 1);
    tick();
    chk("busy_after_hdr", int'(busy), 1);
    // payload
    i  = 0;
    to = 0;
    while (i < exp_len && to < 200) begin
      v        = gapped ? (to % 2 == 0) : 1'b1;
      in_valid = v;
      in_data  = v ? pl[i] : 8'($urandom);
      took     = v && in_ready;
      tick();
      if (took) i++;
      to++;
    end
    in_valid = hold;
    in_data  = nxt;
    // REQ
    chk("req_sel", int'(fifo_sel_bits), int'(exp_sel));
    chk("req_in_ready", int'(in_ready), 0);
    chk("req_no_out", int'(out_valid), 0);
    for (int k = 0; k < gwait; k++) begin
      do w = 4'($urandom); while (w == c_MATCH);
      set_grants(d, w, c_MATCH);
      tick();
      chk("wait_no_out", int'(out_valid), 0);
      chk("wait_sel", int'(fifo_sel_bits), int'(exp_sel));
    end
    set_grants(d, c_MATCH, 4'd0);
    tick();
    set_grants(d, 4'd0, 4'd0);
    chk("first_out_after_grant", int'(out_valid), 1);
    // SEND
    n       = 0;
    lastpos = -1;
    while (out_valid && n < 20) begin
      got[n] = int'(out_data);
      if (out_last) lastpos = n;
      chk("send_sel", int'(fifo_sel_bits), int'(exp_sel));
      chk("send_in_ready", int'(in_ready), 0);
      n++;
      tick();
    end
    chk("send_len", n, exp_len);
    chk("last_pos", lastpos, exp_len - 1);
    for (int k = 0; k < exp_len; k++) chk("payload", got[k], int'(pl[k]));
    // GAP
    for (int k = 0; k < 2; k++) begin
      chk("gap_sel", int'(fifo_sel_bits), 0);
      chk("gap_in_ready", int'(in_ready), 0);
      chk("gap_busy", int'(busy), 1);
      chk("gap_no_out", int'(out_valid), 0);
      tick();
    end
    chk("idle_in_ready", int'(in_ready), 1);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1);
  end

  initial begin
    vec_t       tbl [6];
    logic [7:0] pl [8];
    logic [7:0] h;

    tbl[0] = '{8'h0E, 1'b0, 0,  1'b0, 8'h00, 4'b0100, 4};   // basic
    tbl[1] = '{8'h3C, 1'b0, 1,  1'b0, 8'h00, 4'b0001, 16};  // max length
    tbl[2] = '{8'h01, 1'b0, 0,  1'b0, 8'h00, 4'b0010, 1};   // min length
    tbl[3] = '{8'h0F, 1'b0, 10, 1'b0, 8'h00, 4'b1000, 4};   // wrong grants first
    tbl[4] = '{8'hC6, 1'b1, 2,  1'b1, 8'h15, 4'b0100, 2};   // ignored bits, next hdr held
    tbl[5] = '{8'h15, 1'b1, 3,  1'b0, 8'h00, 4'b0010, 6};   // the held header

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    set_grants(0, 4'd0, 4'd0);
    tick();
    tick();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_sel", int'(fifo_sel_bits), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", int'(in_ready), 1);

    for (int t = 0; t < 6; t++) begin
      frame(tbl[t].hdr, tbl[t].exp_sel, tbl[t].exp_len, tbl[t].gapped,
            tbl[t].gwait, tbl[t].hold, tbl[t].nxt);
    end

    // Reset in the middle of an 8-byte SEND to destination 1
    for (int k = 0; k < 8; k++) pl[k] = 8'($urandom);
    in_valid = 1'b1;
    in_data  = 8'h1D;
    tick();
    for (int k = 0; k < 8; k++) begin
      in_data = pl[k];
      tick();
    end
    in_valid = 1'b0;
    chk("rst_test_req", int'(fifo_sel_bits), 4'b0010);
    set_grants(1, c_MATCH, 4'd0);
    tick();
    set_grants(1, 4'd0, 4'd0);
    chk("rst_test_b0", int'(out_data), int'(pl[0]));
    tick();
    chk("rst_test_b1", int'(out_data), int'(pl[1]));
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_sel", int'(fifo_sel_bits), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("after_midrst_ready", int'(in_ready), 1);
    frame(8'h0A, 4'b0100, 3, 1'b0, 1, 1'b0, 8'h00);

    // Randomized frames against the header-decoding model
    for (int t = 0; t < 20; t++) begin
      h = 8'($urandom);
      frame(h, 4'b0001 << h[1:0], int'(h[5:2]) + 1, 1'($urandom),
            int'($urandom_range(0, 4)), 1'b0, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_req_gen.md
# frame_req_gen

Per-input-port frame front end for the 4x4 switch fabric. It accepts a byte stream from one input port, parses a one-byte frame header, and buffers the payload in a 16-byte internal store. It then raises a one-hot request toward the destination output's FIFO-select arbiter, waits for that arbiter's select code to name this port, and streams the payload onto the shared bus. One instance sits upstream of each of the four output arbiters' request inputs; bit `d` of `fifo_sel_bits` drives request line `PORT_ID` of output arbiter `d`.

## Interface
- `PORT_ID`, 0: index (0-3) of the input port this instance serves.
- `GRANT_BASE`, 4'b0100: arbiter select code for port 0. Port p's grant code is `GRANT_BASE + p`.
- `NON_GRANT`, 4'b0000: arbiter idle code.

- `glb_clk`  in  1  single clock, rising edge.
- `glb_areset_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  input byte.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  block accepts a byte this cycle. A transfer is `in_valid & in_ready`.
- `grant_code_0..3`  in  4 each  registered select outputs of output arbiters 0-3.
- `fifo_sel_bits`  out  4  one-hot request. Bit d requests output d.
- `out_data`  out  8  payload byte toward the bus mux.
- `out_valid`  out  1  `out_data` valid.
- `out_last`  out  1  marks the final payload byte.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Header byte: `[1:0]` = dest d; `[5:2]` = L-1, so payload length L ranges 1..16; `[7:6]` are ignored.
- States:
  - IDLE (`in_ready`=1): a transfer latches dest and L, clears the write pointer, and moves to LOAD.
  - LOAD (`in_ready`=1): each transfer writes `buf[wptr]` and increments `wptr` (4-bit). On the L-th byte, moves to REQ and `in_ready` drops the next cycle.
  - REQ (`in_ready`=0): `fifo_sel_bits` = 1<<d, registered. The block waits indefinitely until `grant_code_d == GRANT_BASE+PORT_ID`. On the cycle that match is seen, moves to SEND and clears `rptr`.
  - SEND: one byte per cycle with no stalls. `out_data`=`buf[rptr]`, `out_valid`=1, and `out_last`=1 when `rptr`==L-1. The request stays asserted through the last byte. After the last byte, moves to GAP.
  - GAP: `fifo_sel_bits`=0 for exactly 2 cycles so the arbiter sees an idle request history and can return to `NON_GRANT`. Then moves to IDLE.
- A grant code naming another port, or `NON_GRANT`, is ignored. A match seen on any grant_code other than d is ignored.
- While this block holds its grant, the arbiter does not preempt it. The block does not re-check the grant during SEND.
- `in_valid` without `in_ready` is neither consumed nor lost. The source must hold it.

## Timing
- Reset values: `in_ready`=0 during reset and 1 in the first cycle after release (IDLE). `fifo_sel_bits`=0, `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0. State=IDLE, pointers=0.
- Request latency: `fifo_sel_bits` goes high 1 cycle after the last payload byte is accepted.
- Grant latency: the arbiter responds no earlier than 1 cycle after the request. SEND's first `out_valid` occurs 1 cycle after the matching grant code is first seen.
- Transfer duration: `out_valid` stays high for exactly L consecutive cycles. The request drops in the cycle after `out_last`.
- Minimum frame period, with grant at the earliest point: 1 header + L load + 1 REQ + 1 grant + L send + 2 GAP cycles.
- `busy` rises the cycle after the header is accepted and falls on re-entry to IDLE.
- Reset mid-operation: all outputs go immediately to their reset values, the buffered frame is discarded, and the request drops asynchronously.

## Test plan
- Basic frame: header 8'h0E (d=2, L=4) then 11,22,33,44, arbiter 2 grants 4'b0110 with PORT_ID=2 → `fifo_sel_bits`=4'b0100 one cycle after byte 44; then `out_data` 11,22,33,44 over 4 consecutive cycles with `out_last` on 44; request low for 2 cycles; `in_ready` high again afterwards.
- Maximum length: header 8'h3C (d=0, L=16), bytes 0..15 → all 16 bytes output in order and `wptr`/`rptr` wrap cleanly. Minimum length: header 8'h01 (d=1, L=1) → a single byte with `out_valid` and `out_last` together.
- Wrong grant: PORT_ID=1 requesting d=3 while `grant_code_3`=4'b0100 for 10 cycles, then 4'b0101 → no `out_valid` until the cycle after 4'b0101 appears. A matching code on `grant_code_0` causes no output.
- Backpressure: `in_valid` held high with a second header queued behind the first frame → `in_ready`=0 from REQ through GAP, and the second header is accepted only in IDLE.
- Reset mid-SEND: assert `glb_areset_n`=0 after 2 of 8 bytes → `out_valid` and `fifo_sel_bits` drop immediately. After release, a new frame runs normally with no leftover bytes.
- Gapped input: `in_valid` toggled 1,0,1,0 during LOAD → only qualified bytes are stored, and output order and L are correct.
